// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the memory bus arbiter.
// Handshake polarity is active-low: ENABLE_ drives a breq_/bgrt_ line low.
package bus_arbiter_pkg;

    localparam logic ENABLE_        = 1'b0;
    localparam logic DISABLE_       = 1'b1;
    localparam int   DATA_WIDTH     = 32;
    localparam int   BUS_ADDR_WIDTH = 32;
    localparam int   WCNT_W         = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_GRANT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin encoder: returns the first set request at or after ptr,
// scanning upward in index with wrap-around.
module bus_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // Scan the largest offset first so the nearest requester is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among NUM_MASTERS active-low breq_/bgrt_
// masters, with optional fixed memory wait states and owner-muxed memory port.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int MEM_WAIT    = 0,
    localparam int PTR_W       = $clog2(NUM_MASTERS)
) (
    input  logic                                 clk,
    input  logic                                 reset_,
    input  logic [NUM_MASTERS-1:0]               m_breq_,
    input  logic [NUM_MASTERS-1:0]               m_memread,
    input  logic [NUM_MASTERS-1:0]               m_memwrite,
    input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_writedata,
    output logic [NUM_MASTERS-1:0]               m_bgrt_,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [BUS_ADDR_WIDTH-1:0]            mem_adr,
    output logic [DATA_WIDTH-1:0]                mem_writedata,
    output logic [PTR_W-1:0]                     owner,
    output logic                                 busy
);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic [PTR_W-1:0]       pick_ptr;
    logic                   pick_valid;
    logic [PTR_W-1:0]       pick_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_MASTERS - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // In GRANT the retiring owner is masked and the search starts just past it.
    always_comb begin
        eligible = ~m_breq_;
        pick_ptr = rr_ptr_q;
        if (state_q == ARB_GRANT) begin
            eligible[owner_q] = 1'b0;
            pick_ptr          = ptr_inc(owner_q);
        end
    end

    bus_arbiter_rr_pick #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (eligible),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            ARB_IDLE, ARB_GRANT: begin
                if (state_q == ARB_GRANT) begin
                    rr_ptr_d = ptr_inc(owner_q);
                end
                if (pick_valid) begin
                    owner_d = pick_idx;
                    if (MEM_WAIT > 0) begin
                        state_d = ARB_ACCESS;
                        wcnt_d  = WCNT_W'(MEM_WAIT - 1);
                    end else begin
                        state_d = ARB_GRANT;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                if (m_breq_[owner_q] == DISABLE_) begin
                    state_d = ARB_IDLE;
                end else if (wcnt_q == '0) begin
                    state_d = ARB_GRANT;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Grant and busy decode from flops only; the memory port follows the owner's live strobes.
    always_comb begin
        m_bgrt_       = {NUM_MASTERS{DISABLE_}};
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_adr       = '0;
        mem_writedata = '0;
        if (state_q == ARB_GRANT) begin
            m_bgrt_[owner_q] = ENABLE_;
        end
        if (state_q != ARB_IDLE) begin
            mem_read      = m_memread[owner_q];
            mem_write     = m_memwrite[owner_q];
            mem_adr       = m_adr[int'(owner_q)*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
            mem_writedata = m_writedata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a zero-wait instance driven from a vector table and a
// two-wait-state instance exercised with hand-written multi-cycle sequences.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_;
    logic [1:0]  breq_;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [63:0] adr;
    logic [63:0] wd;

    logic [1:0]  a_bgrt_, b_bgrt_;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_adr, a_wd, b_adr, b_wd;
    logic        a_owner, b_owner, a_busy, b_busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_MASTERS(2), .MEM_WAIT(0)) u_w0 (
        .clk(clk), .reset_(reset_), .m_breq_(breq_), .m_memread(rd), .m_memwrite(wr),
        .m_adr(adr), .m_writedata(wd), .m_bgrt_(a_bgrt_), .mem_read(a_rd), .mem_write(a_wr),
        .mem_adr(a_adr), .mem_writedata(a_wd), .owner(a_owner), .busy(a_busy)
    );

    bus_arbiter #(.NUM_MASTERS(2), .MEM_WAIT(2)) u_w2 (
        .clk(clk), .reset_(reset_), .m_breq_(breq_), .m_memread(rd), .m_memwrite(wr),
        .m_adr(adr), .m_writedata(wd), .m_bgrt_(b_bgrt_), .mem_read(b_rd), .mem_write(b_wr),
        .mem_adr(b_adr), .mem_writedata(b_wd), .owner(b_owner), .busy(b_busy)
    );

    typedef struct {
        logic [1:0]  breq_, rd, wr;
        logic [31:0] adr0, adr1;
        logic [1:0]  e_bgrt_;
        logic        e_rd, e_wr;
        logic [31:0] e_adr, e_wd;
        logic        e_owner, e_busy;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [69:0] pack(input logic [1:0] g, input logic r, input logic w,
                                         input logic [31:0] a, input logic [31:0] d,
                                         input logic o, input logic b);
        return {g, r, w, a, d, o, b};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got bgrt_=%b rd=%b wr=%b adr=%h wd=%h owner=%b busy=%b, want bgrt_=%b rd=%b wr=%b adr=%h wd=%h owner=%b busy=%b",
                     name, act[69:68], act[67], act[66], act[65:34], act[33:2], act[1], act[0],
                     exp[69:68], exp[67], exp[66], exp[65:34], exp[33:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [69:0] act_a();
        return pack(a_bgrt_, a_rd, a_wr, a_adr, a_wd, a_owner, a_busy);
    endfunction

    function automatic logic [69:0] act_b();
        return pack(b_bgrt_, b_rd, b_wr, b_adr, b_wd, b_owner, b_busy);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        breq_  = 2'b11;
        rd     = 2'b00;
        wr     = 2'b00;
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b10, 2'b01, 2'b00, 32'h010, 32'h020, 2'b10, 1'b1, 1'b0, 32'h010, 32'hAAAA, 1'b0, 1'b1};
        vecs[1]  = '{2'b11, 2'b00, 2'b00, 32'h010, 32'h020, 2'b11, 1'b0, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 2'b11, 2'b00, 32'h100, 32'h200, 2'b01, 1'b1, 1'b0, 32'h200, 32'hBBBB, 1'b1, 1'b1};
        vecs[3]  = '{2'b10, 2'b11, 2'b00, 32'h100, 32'h200, 2'b10, 1'b1, 1'b0, 32'h100, 32'hAAAA, 1'b0, 1'b1};
        vecs[4]  = '{2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 2'b11, 1'b0, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 2'b01, 2'b00, 32'h040, 32'h000, 2'b10, 1'b1, 1'b0, 32'h040, 32'hAAAA, 1'b0, 1'b1};
        vecs[6]  = '{2'b10, 2'b01, 2'b00, 32'h040, 32'h000, 2'b11, 1'b0, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 2'b01, 2'b00, 32'h040, 32'h000, 2'b10, 1'b1, 1'b0, 32'h040, 32'hAAAA, 1'b0, 1'b1};
        vecs[8]  = '{2'b10, 2'b01, 2'b00, 32'h040, 32'h000, 2'b11, 1'b0, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 2'b00, 2'b00, 32'h000, 32'h080, 2'b01, 1'b0, 1'b0, 32'h080, 32'hBBBB, 1'b1, 1'b1};
        vecs[10] = '{2'b11, 2'b00, 2'b00, 32'h000, 32'h080, 2'b11, 1'b0, 1'b0, 32'h000, 32'h0000, 1'b1, 1'b0};
        vecs[11] = '{2'b10, 2'b01, 2'b01, 32'h0F0, 32'h000, 2'b10, 1'b1, 1'b1, 32'h0F0, 32'hAAAA, 1'b0, 1'b1};
        vecs[12] = '{2'b11, 2'b00, 2'b00, 32'h0F0, 32'h000, 2'b11, 1'b0, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b0};

        reset_ = 1'b0;
        breq_  = 2'b11;
        rd     = 2'b00;
        wr     = 2'b00;
        adr    = {32'h0000_0020, 32'h0000_0010};
        wd     = {32'h0000_BBBB, 32'h0000_AAAA};
        repeat (3) @(posedge clk);
        #1;
        check("reset_w0", act_a(), pack(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        check("reset_w2", act_b(), pack(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        @(negedge clk);
        reset_ = 1'b1;

        // Zero-wait table: single read, rotation, held request, strobe pass-through
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            breq_ = vecs[i].breq_;
            rd    = vecs[i].rd;
            wr    = vecs[i].wr;
            adr   = {vecs[i].adr1, vecs[i].adr0};
            @(posedge clk);
            #1;
            check($sformatf("w0_vec%0d", i), act_a(),
                  pack(vecs[i].e_bgrt_, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_adr,
                       vecs[i].e_wd, vecs[i].e_owner, vecs[i].e_busy));
        end

        // Two wait states: master 1 write held stable through ACCESS, granted in cycle 3
        do_reset();
        @(negedge clk);
        breq_ = 2'b01;
        wr    = 2'b10;
        adr   = {32'h0000_03FF, 32'h0};
        wd    = {32'hDEAD_BEEF, 32'h0000_AAAA};
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c < 3) begin
                check($sformatf("w2_write_c%0d", c), act_b(),
                      pack(2'b11, 1'b0, 1'b1, 32'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b1));
            end else if (c == 3) begin
                check("w2_write_c3", act_b(),
                      pack(2'b01, 1'b0, 1'b1, 32'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b1));
                @(negedge clk);
                breq_ = 2'b11;
            end else begin
                check("w2_write_c4", act_b(),
                      pack(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
            end
        end

        // Master 0 abandons its request during the second ACCESS cycle
        do_reset();
        @(negedge clk);
        breq_ = 2'b10;
        rd    = 2'b01;
        wr    = 2'b00;
        adr   = {32'h0000_0456, 32'h0000_0123};
        @(posedge clk);
        #1;
        check("w2_abort_c1", act_b(), pack(2'b11, 1'b1, 1'b0, 32'h123, 32'hAAAA, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        check("w2_abort_c2", act_b(), pack(2'b11, 1'b1, 1'b0, 32'h123, 32'hAAAA, 1'b0, 1'b1));
        @(negedge clk);
        breq_ = 2'b11;
        @(posedge clk);
        #1;
        check("w2_abort_c3", act_b(), pack(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("w2_abort_c4", act_b(), pack(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        // Pointer must still favour master 0 when both ask together
        @(negedge clk);
        breq_ = 2'b00;
        rd    = 2'b11;
        @(posedge clk);
        #1;
        check("w2_ptr_kept", act_b(), pack(2'b11, 1'b1, 1'b0, 32'h123, 32'hAAAA, 1'b0, 1'b1));

        // Asynchronous reset in the middle of ACCESS
        #2;
        reset_ = 1'b0;
        #1;
        check("w2_async_reset", act_b(), pack(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        check("w0_async_reset", act_a(), pack(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        @(negedge clk);
        breq_  = 2'b11;
        reset_ = 1'b1;
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
